// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one 4-bit ALU between two requesters.
// Round-robin arbitration, registered ALU operands, per-requester
// valid/ready response channels. Only one operation is outstanding at a time.
// Optional macro ALU_SHARE_CTRL_STATS_EN adds saturating per-requester
// completion counters (stat_cnt0 / stat_cnt1).
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | arbitrate; winner's reqN_ready is high; handshake loads the ALU
//   EXEC  | ALU evaluates from registered inputs; result captured at the end
//   RESP  | respN_valid held with stable data until respN_ready
module alu_share_ctrl #(
  parameter int DW   = 4,
  parameter int OPW  = 3,
  parameter int CNTW = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  output logic           resp0_valid,
  input  logic           resp0_ready,
  output logic [DW-1:0]  resp0_data,
  output logic           resp0_cout,
  output logic           resp1_valid,
  input  logic           resp1_ready,
  output logic [DW-1:0]  resp1_data,
  output logic           resp1_cout,
  output logic [OPW-1:0] ALU_option,
  output logic [DW-1:0]  ALU_in1,
  output logic [DW-1:0]  ALU_in2,
  input  logic [DW-1:0]  ALU_out,
  input  logic           ALU_Cout,
  output logic           busy,
  output logic           grant_id
`ifdef ALU_SHARE_CTRL_STATS_EN
  ,
  output logic [CNTW-1:0] stat_cnt0,
  output logic [CNTW-1:0] stat_cnt1
`endif
);

  // The controller is tied to the 4-bit / 3-bit-opcode ALU.
  if (DW != 4 || OPW != 3 || CNTW < 1) begin : g_bad_params
    $error("alu_share_ctrl: DW must be 4, OPW must be 3, CNTW must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state_q, state_d;
  logic   last_grant_q;
  logic   win;
  logic   any_valid;
  logic   grant_ready;
  logic   accept;
  logic   capture;
  logic   release_resp;
  logic   cout_eff;

  // Tie goes to the requester that did not win last time.
  assign any_valid   = req0_valid | req1_valid;
  assign win         = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
  assign grant_ready = grant_id ? resp1_ready : resp0_ready;
  assign busy        = (state_q != IDLE);
  // The ALU leaves Cout stale for logic ops; only add (000) and sub (001) carry.
  assign cout_eff    = (ALU_option[OPW-1:1] == '0) ? ALU_Cout : 1'b0;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d      = state_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    accept       = 1'b0;
    capture      = 1'b0;
    release_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          req0_ready = ~win;
          req1_ready = win;
          accept     = 1'b1;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        capture = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (grant_ready) begin
          release_resp = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, result capture and response channel registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      grant_id     <= 1'b0;
      ALU_option   <= '0;
      ALU_in1      <= '0;
      ALU_in2      <= '0;
      resp0_valid  <= 1'b0;
      resp0_data   <= '0;
      resp0_cout   <= 1'b0;
      resp1_valid  <= 1'b0;
      resp1_data   <= '0;
      resp1_cout   <= 1'b0;
    end else begin
      if (accept) begin
        grant_id   <= win;
        ALU_option <= win ? req1_op : req0_op;
        ALU_in1    <= win ? req1_a  : req0_a;
        ALU_in2    <= win ? req1_b  : req0_b;
      end
      if (capture) begin
        if (grant_id) begin
          resp1_data  <= ALU_out;
          resp1_cout  <= cout_eff;
          resp1_valid <= 1'b1;
        end else begin
          resp0_data  <= ALU_out;
          resp0_cout  <= cout_eff;
          resp0_valid <= 1'b1;
        end
      end
      if (release_resp) begin
        last_grant_q <= grant_id;
        if (grant_id) resp1_valid <= 1'b0;
        else          resp0_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_SHARE_CTRL_STATS_EN
  // Saturating count of completed response handshakes per requester.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_cnt0 <= '0;
      stat_cnt1 <= '0;
    end else if (release_resp) begin
      if (grant_id) begin
        if (stat_cnt1 != {CNTW{1'b1}}) stat_cnt1 <= stat_cnt1 + {{(CNTW-1){1'b0}}, 1'b1};
      end else begin
        if (stat_cnt0 != {CNTW{1'b1}}) stat_cnt0 <= stat_cnt0 + {{(CNTW-1){1'b0}}, 1'b1};
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: behavioural ALU, table of hand-computed vectors,
// response scoreboard, and directed sequences for back-pressure, round-robin
// and reset-during-EXEC.
module tb_alu_share_ctrl;
  localparam int DW  = 4;
  localparam int OPW = 3;
`ifdef ALU_SHARE_CTRL_STATS_EN
  localparam int CNTW = 2;
`else
  localparam int CNTW = 8;
`endif

  logic clk = 1'b0;
  logic reset;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [OPW-1:0] req0_op, req1_op;
  logic [DW-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic resp0_valid, resp0_ready, resp0_cout, resp1_valid, resp1_ready, resp1_cout;
  logic [DW-1:0]  resp0_data, resp1_data;
  logic [OPW-1:0] ALU_option;
  logic [DW-1:0]  ALU_in1, ALU_in2, ALU_out;
  logic ALU_Cout, busy, grant_id;
`ifdef ALU_SHARE_CTRL_STATS_EN
  logic [CNTW-1:0] stat_cnt0, stat_cnt1;
`endif

  always #5 clk = ~clk;

  alu_share_ctrl #(.DW(DW), .OPW(OPW), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data), .resp0_cout(resp0_cout),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data), .resp1_cout(resp1_cout),
    .ALU_option(ALU_option), .ALU_in1(ALU_in1), .ALU_in2(ALU_in2),
    .ALU_out(ALU_out), .ALU_Cout(ALU_Cout), .busy(busy), .grant_id(grant_id)
`ifdef ALU_SHARE_CTRL_STATS_EN
    , .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1)
`endif
  );

  // Behavioural ALU: logic ops drive a junk carry of 1 (stale Cout).
  function automatic logic [4:0] alu_raw(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'd0: return {1'b0, a} + {1'b0, b};
      3'd1: return {1'b0, a} - {1'b0, b};
      3'd2: return {1'b1, a & b};
      3'd3: return {1'b1, a | b};
      3'd4: return {1'b1, ~a};
      3'd5: return {1'b1, a ^ b};
      3'd6: return {1'b1, a << 1};
      default: return {1'b1, a >> 1};
    endcase
  endfunction

  assign {ALU_Cout, ALU_out} = alu_raw(ALU_option, ALU_in1, ALU_in2);

  // Expected response: carry only meaningful for add/sub.
  function automatic logic [4:0] exp_res(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] r;
    r = alu_raw(op, a, b);
    return {(op < 3'd2) ? r[4] : 1'b0, r[3:0]};
  endfunction

  typedef struct {
    logic       id;
    logic [3:0] d;
    logic       c;
  } sb_t;

  typedef struct {
    logic       id;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] d;
    logic       c;
  } vec_t;

  sb_t  sb[$];
  logic grant_log[$];
  int   n_chk = 0;
  int   n_fail = 0;
  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_check(input logic id, input logic [3:0] d, input logic c);
    sb_t e;
    if (sb.size() == 0) begin
      check("sb_unexpected_resp", 1, 0);
    end else begin
      e = sb.pop_front();
      check("sb_id", id, e.id);
      check("sb_data", d, e.d);
      check("sb_cout", c, e.c);
    end
  endtask

  // Scoreboard push on request handshake, pop on response handshake.
  always @(negedge clk) begin
    logic [4:0] r;
    if (!reset) begin
      if (req0_valid && req0_ready) begin
        r = exp_res(req0_op, req0_a, req0_b);
        sb.push_back('{1'b0, r[3:0], r[4]});
        grant_log.push_back(1'b0);
      end
      if (req1_valid && req1_ready) begin
        r = exp_res(req1_op, req1_a, req1_b);
        sb.push_back('{1'b1, r[3:0], r[4]});
        grant_log.push_back(1'b1);
      end
      if (busy) check("ready_while_busy", {req0_ready, req1_ready}, 0);
      if (resp0_valid || resp1_valid) check("one_resp_only", resp0_valid & resp1_valid, 0);
      if (resp0_valid && resp0_ready) pop_check(1'b0, resp0_data, resp0_cout);
      if (resp1_valid && resp1_ready) pop_check(1'b1, resp1_data, resp1_cout);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    sb.delete();
    grant_log.delete();
  endtask

  task automatic run_vec(input vec_t v);
    int w;
    int lat;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    if (v.id) begin
      req1_op = v.op; req1_a = v.a; req1_b = v.b; req1_valid = 1'b1;
    end else begin
      req0_op = v.op; req0_a = v.a; req0_b = v.b; req0_valid = 1'b1;
    end
    w = 0;
    @(negedge clk);
    while (!(v.id ? req1_ready : req0_ready) && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("req_ready_wait", w, 0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check("exec_busy", busy, 1);
    check("exec_grant_id", grant_id, v.id);
    check("exec_alu_ports", {ALU_option, ALU_in1, ALU_in2}, {v.op, v.a, v.b});
    lat = 1;
    while (!(v.id ? resp1_valid : resp0_valid) && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("resp_latency", lat, 2);
    check("resp_data", v.id ? resp1_data : resp0_data, v.d);
    check("resp_cout", v.id ? resp1_cout : resp0_cout, v.c);
    tick();
  endtask

  initial begin
    int w;
    reset = 1'b1;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;

    vecs[0]  = '{1'b0, 3'd0, 4'h9, 4'h8, 4'h1, 1'b1};
    vecs[1]  = '{1'b0, 3'd0, 4'hF, 4'h1, 4'h0, 1'b1};
    vecs[2]  = '{1'b0, 3'd2, 4'hC, 4'hA, 4'h8, 1'b0};
    vecs[3]  = '{1'b1, 3'd5, 4'h6, 4'h3, 4'h5, 1'b0};
    vecs[4]  = '{1'b1, 3'd1, 4'h3, 4'h5, 4'hE, 1'b1};
    vecs[5]  = '{1'b0, 3'd1, 4'h7, 4'h2, 4'h5, 1'b0};
    vecs[6]  = '{1'b1, 3'd3, 4'h9, 4'h4, 4'hD, 1'b0};
    vecs[7]  = '{1'b0, 3'd4, 4'h5, 4'h0, 4'hA, 1'b0};
    vecs[8]  = '{1'b1, 3'd6, 4'h9, 4'h0, 4'h2, 1'b0};
    vecs[9]  = '{1'b0, 3'd7, 4'h9, 4'h0, 4'h4, 1'b0};
    vecs[10] = '{1'b1, 3'd0, 4'h7, 4'h8, 4'hF, 1'b0};

    do_reset();
    @(negedge clk);
    check("rst_alu_ports", {ALU_option, ALU_in1, ALU_in2}, 0);
    check("rst_resp_valid", {resp0_valid, resp1_valid}, 0);
    check("rst_resp_data", {resp0_data, resp0_cout, resp1_data, resp1_cout}, 0);
    check("rst_busy_grant", {busy, grant_id}, 0);
    check("rst_req_ready", {req0_ready, req1_ready}, 0);
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);
    tick();
    check("table_sb_drained", sb.size(), 0);

    // Both requesters held valid: grants alternate starting with 0.
    do_reset();
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    req0_op = 3'd0; req0_a = 4'h1; req0_b = 4'h2;
    req1_op = 3'd1; req1_a = 4'h4; req1_b = 4'h6;
    req0_valid = 1'b1; req1_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (grant_log.size() < 4 && w < 40) begin
      @(negedge clk);
      w++;
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("rr_grant_count", grant_log.size(), 4);
    if (grant_log.size() >= 4) begin
      check("rr_grant_order", {grant_log[0], grant_log[1], grant_log[2], grant_log[3]}, 4'b0101);
    end
    repeat (5) tick();
    check("rr_sb_drained", sb.size(), 0);

    // Back-pressure on resp0 while req1 waits.
    resp0_ready = 1'b0; resp1_ready = 1'b1;
    req0_op = 3'd0; req0_a = 4'h3; req0_b = 4'h4; req0_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!req0_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("bp_req0_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    req1_op = 3'd3; req1_a = 4'h1; req1_b = 4'h2; req1_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!resp0_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_resp0_hold", {resp0_valid, resp0_data, resp0_cout}, {1'b1, 4'h7, 1'b0});
      check("bp_req_ready_low", {req0_ready, req1_ready}, 0);
      @(negedge clk);
    end
    tick();
    resp0_ready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("bp_req1_next", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    repeat (4) tick();
    check("bp_sb_drained", sb.size(), 0);

    // Reset pulsed during EXEC aborts the operation.
    req0_op = 3'd0; req0_a = 4'h2; req0_b = 4'h2; req0_valid = 1'b1;
    @(negedge clk);
    check("abort_req0_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_resp", {resp0_valid, resp1_valid}, 0);
    end
    check("abort_outputs_zero",
          {ALU_option, ALU_in1, ALU_in2, resp0_data, resp0_cout, resp1_data, resp1_cout, busy, grant_id}, 0);
    tick();
    run_vec('{1'b1, 3'd5, 4'h6, 4'h3, 4'h5, 1'b0});

`ifdef ALU_SHARE_CTRL_STATS_EN
    do_reset();
    @(negedge clk);
    check("stat_rst", {stat_cnt0, stat_cnt1}, 0);
    tick();
    for (int i = 0; i < 5; i++) run_vec('{1'b0, 3'd0, 4'h1, 4'h1, 4'h2, 1'b0});
    for (int i = 0; i < 2; i++) run_vec('{1'b1, 3'd2, 4'hF, 4'h3, 4'h3, 1'b0});
    @(negedge clk);
    check("stat_cnt0_sat", stat_cnt0, 3);
    check("stat_cnt1", stat_cnt1, 2);
`endif

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
